// File: rtl/phantom_txn_sequencer.sv
// Sequences the INIT_AXI_TXN / TXN_DONE / ERROR handshakes of the phantom_dummy AXI masters,
// one after another or all at once, with a per-launch timeout and a single pass/fail result.
module phantom_txn_sequencer #(
    parameter int NUM_MASTERS    = 4,
    parameter int START_DELAY    = 25,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   start,
    input  logic                   mode,
    input  logic [NUM_MASTERS-1:0] enable_mask,
    output logic [NUM_MASTERS-1:0] init_axi_txn,
    input  logic [NUM_MASTERS-1:0] txn_done,
    input  logic [NUM_MASTERS-1:0] txn_error,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_MASTERS-1:0] err_vec,
    output logic [NUM_MASTERS-1:0] timeout_vec,
    output logic [2:0]             dbg_state
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] DELAY_END   = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_LAUNCH, S_WAIT, S_NEXT, S_REPORT
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]       cur_q, cur_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] txn_done_q;
    logic [NUM_MASTERS-1:0] cmp_q, cmp_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;
    logic [NUM_MASTERS-1:0] to_q, to_d;
    logic                   pass_q, pass_d;

    logic [NUM_MASTERS-1:0] cur_onehot, eligible, edge_vld, cmp_now;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   timeout_hit, all_done, pass_now, next_found;
    logic [IDX_W-1:0]       first_idx, next_idx;

    // Handshake: init_axi_txn is a one-cycle launch pulse; completion is the rising edge of
    // txn_done seen in LAUNCH/WAIT, so a level left high from an earlier run never counts.
    always_comb begin
        cur_onehot  = NUM_MASTERS'(1) << cur_q;
        eligible    = mode_q ? mask_q : (mask_q & cur_onehot);
        edge_vld    = '0;
        if (state_q == S_LAUNCH || state_q == S_WAIT)
            edge_vld = txn_done & ~txn_done_q & eligible & ~cmp_q;
        cmp_now     = cmp_q | edge_vld;
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (cnt_inc == TIMEOUT_END);
        all_done    = ((cmp_now & mask_q) == mask_q);
        pass_now    = ~|(err_q | to_q);

        first_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (enable_mask[i]) first_idx = IDX_W'(i);

        next_idx   = cur_q;
        next_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (mask_q[i] && (IDX_W'(i) > cur_q)) begin
                next_idx   = IDX_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (START_DELAY == 0) ? S_LAUNCH : S_DELAY;
            S_DELAY:  if (cnt_inc == DELAY_END) state_d = S_LAUNCH;
            S_LAUNCH: state_d = (mask_q == '0) ? S_REPORT : S_WAIT;
            S_WAIT: begin
                if (!mode_q) begin
                    if (cmp_now[cur_q] || timeout_hit) state_d = S_NEXT;
                end else begin
                    if (all_done || timeout_hit) state_d = S_REPORT;
                end
            end
            S_NEXT:   state_d = next_found ? S_LAUNCH : S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        init_axi_txn = '0;
        if (state_q == S_LAUNCH)
            init_axi_txn = mode_q ? mask_q : (mask_q & cur_onehot);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_REPORT);
        // The REPORT cycle already shows the result it is about to latch.
        pass        = (state_q == S_REPORT) ? pass_now : pass_q;
        err_vec     = err_q;
        timeout_vec = to_q;
        dbg_state   = state_q;
    end

    always_comb begin
        mode_d = mode_q;
        mask_d = mask_q;
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        cmp_d  = cmp_now;
        err_d  = err_q;
        to_d   = to_q;
        pass_d = pass_q;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (edge_vld[i]) err_d[i] = txn_error[i];
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    mode_d = mode;
                    mask_d = enable_mask;
                    cur_d  = first_idx;
                    cmp_d  = '0;
                    err_d  = '0;
                    to_d   = '0;
                    pass_d = 1'b0;
                end
            end
            S_DELAY:  cnt_d = cnt_inc;
            S_LAUNCH: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    if (mode_q)               to_d = to_q | (mask_q & ~cmp_now);
                    else if (!cmp_now[cur_q]) to_d[cur_q] = 1'b1;
                end
            end
            S_NEXT:   if (next_found) cur_d = next_idx;
            S_REPORT: pass_d = pass_now;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mode_q     <= 1'b0;
            mask_q     <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            txn_done_q <= '0;
            cmp_q      <= '0;
            err_q      <= '0;
            to_q       <= '0;
            pass_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            txn_done_q <= txn_done;
            cmp_q      <= cmp_d;
            err_q      <= err_d;
            to_q       <= to_d;
            pass_q     <= pass_d;
        end
    end
endmodule

// File: tb/tb_phantom_txn_sequencer.sv
// Bench for phantom_txn_sequencer: behavioural master responders, an expected launch queue
// computed from the sequencing rules, and result checks at every REPORT.
module tb_phantom_txn_sequencer;
    localparam int NM = 4;
    localparam int SD = 25;
    localparam int TO = 100;
    localparam int W  = 36;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, mode;
    logic [3:0] enable_mask, init_axi_txn, txn_done, txn_error, err_vec, timeout_vec;
    logic       busy, done, pass;
    logic [2:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Responder config: -1 = ignore launches entirely, 0 = drop done and never answer,
    // k > 0 = raise txn_done k cycles after the launch.
    int            dly_cfg[NM];
    logic [NM-1:0] err_cfg;
    int            rise_at[NM];

    logic [W-1:0] exp_q[$];
    int           exp_rep;
    logic [3:0]   exp_err, exp_to;
    logic         exp_pass;

    phantom_txn_sequencer #(
        .NUM_MASTERS(NM), .START_DELAY(SD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(clk), .ARESET(rst), .start(start), .mode(mode), .enable_mask(enable_mask),
        .init_axi_txn(init_axi_txn), .txn_done(txn_done), .txn_error(txn_error),
        .busy(busy), .done(done), .pass(pass), .err_vec(err_vec),
        .timeout_vec(timeout_vec), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    endtask

    task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] e);
        dly_cfg[0] = d0; dly_cfg[1] = d1; dly_cfg[2] = d2; dly_cfg[3] = d3;
        err_cfg = e;
    endtask

    function automatic bit completes(input int i);
        return (dly_cfg[i] > 0) && (dly_cfg[i] <= TO);
    endfunction

    // Reference: launch times and results from the sequencing rules, start sampled at cycle n.
    task automatic build_model(input logic md, input logic [3:0] msk, input int n);
        int t, w;
        exp_q.delete();
        exp_err = '0;
        exp_to  = '0;
        t = n + 1 + SD;
        if (msk == 4'd0) begin
            exp_rep = n + 2 + SD;
        end else if (!md) begin
            for (int i = 0; i < NM; i++) begin
                if (msk[i]) begin
                    exp_q.push_back({32'(t), 4'(1 << i)});
                    if (completes(i)) begin
                        exp_err[i] = err_cfg[i];
                        t = t + dly_cfg[i] + 2;
                    end else begin
                        exp_to[i] = 1'b1;
                        t = t + TO + 2;
                    end
                end
            end
            exp_rep = t;
        end else begin
            exp_q.push_back({32'(t), msk});
            w = t;
            for (int i = 0; i < NM; i++) begin
                if (msk[i]) begin
                    if (completes(i)) begin
                        exp_err[i] = err_cfg[i];
                        if (t + dly_cfg[i] > w) w = t + dly_cfg[i];
                    end else begin
                        exp_to[i] = 1'b1;
                        if (t + TO > w) w = t + TO;
                    end
                end
            end
            exp_rep = w + 1;
        end
        exp_pass = ((exp_err | exp_to) == 4'd0);
    endtask

    // One clock: wait for the falling edge, then let each master responder react.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NM; i++) begin
            if (init_axi_txn[i] && dly_cfg[i] >= 0) begin
                txn_done[i]  = 1'b0;
                txn_error[i] = 1'b0;
                rise_at[i]   = (dly_cfg[i] > 0) ? cyc + dly_cfg[i] : -1;
            end else if (rise_at[i] == cyc) begin
                txn_done[i]  = 1'b1;
                txn_error[i] = err_cfg[i];
                rise_at[i]   = -1;
            end
        end
    endtask

    task automatic begin_run(input logic md, input logic [3:0] msk, output int n);
        for (int i = 0; i < NM; i++) rise_at[i] = -1;
        step();
        check("idle_busy", 64'(busy), 64'(0));
        n = cyc;
        start = 1'b1;
        mode = md;
        enable_mask = msk;
        build_model(md, msk, n);
    endtask

    task automatic run(input string name, input logic md, input logic [3:0] msk,
                       input int extra_start);
        int n;
        bit seen;
        begin_run(md, msk, n);
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            step();
            if (cyc - n == extra_start) begin
                start = 1'b1; mode = ~md; enable_mask = 4'hF;
            end else begin
                start = 1'b0; mode = 1'($urandom); enable_mask = 4'($urandom);
            end
            if (cyc - n == 1) check({name, " busy_rise"}, 64'(busy), 64'(1));
            if (init_axi_txn != 4'd0) begin
                if (exp_q.size() == 0)
                    check({name, " extra_launch"}, 64'({32'(cyc), init_axi_txn}), 64'(0));
                else
                    check({name, " launch"}, 64'({32'(cyc), init_axi_txn}), 64'(exp_q.pop_front()));
            end
            if (done) begin
                seen = 1'b1;
                check({name, " report_cycle"}, 64'(cyc - n), 64'(exp_rep - n));
                check({name, " pass"}, 64'(pass), 64'(exp_pass));
                check({name, " err_vec"}, 64'(err_vec), 64'(exp_err));
                check({name, " timeout_vec"}, 64'(timeout_vec), 64'(exp_to));
            end
        end
        start = 1'b0;
        check({name, " done_seen"}, 64'(seen), 64'(1));
        check({name, " launches_left"}, 64'(exp_q.size()), 64'(0));
        step();
        check({name, " after_report busy_done"}, 64'({busy, done}), 64'(0));
        check({name, " pass_held"}, 64'(pass), 64'(exp_pass));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; enable_mask = 4'd0;
        txn_done = 4'd0; txn_error = 4'd0;
        set_cfg(0, 0, 0, 0, 4'd0);
        for (int i = 0; i < NM; i++) rise_at[i] = -1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({init_axi_txn, busy, done, pass, err_vec, timeout_vec}), 64'(0));
        rst = 1'b0;

        set_cfg(40, 40, 40, 40, 4'b0000);
        run("seq_all", 1'b0, 4'b1111, 5);
        set_cfg(30, 90, 0, 60, 4'b1000);
        run("conc_1011", 1'b1, 4'b1011, -1);
        set_cfg(0, 0, 5, 0, 4'b0000);
        run("seq_timeout", 1'b0, 4'b0110, -1);
        set_cfg(-1, 0, 0, 0, 4'b0000);
        txn_done[0] = 1'b1;
        run("held_high", 1'b0, 4'b0001, -1);
        set_cfg(10, 0, 0, 0, 4'b0000);
        txn_done[0] = 1'b1;
        run("held_then_edge", 1'b0, 4'b0001, -1);
        set_cfg(0, 0, 0, 0, 4'b0000);
        run("mask_zero", 1'b0, 4'b0000, 3);
        set_cfg(TO, 0, 0, 0, 4'b0000);
        run("seq_edge_at_timeout", 1'b0, 4'b0001, -1);
        set_cfg(0, 0, TO + 1, 0, 4'b0100);
        run("conc_edge_after_timeout", 1'b1, 4'b0100, -1);
        set_cfg(TO, TO, TO, TO, 4'b0000);
        run("conc_all_at_timeout", 1'b1, 4'b1111, -1);

        // Reset while M03 waits, after M00 has already captured an error.
        set_cfg(10, 0, 0, 0, 4'b0001);
        begin_run(1'b0, 4'b1001, n);
        while (cyc < n + 43) begin
            step();
            start = 1'b0;
        end
        check("pre_reset err_vec", 64'(err_vec), 64'(4'b0001));
        check("pre_reset busy", 64'(busy), 64'(1));
        #1 rst = 1'b1;
        #1 check("async_reset_wait outputs",
                 64'({init_axi_txn, busy, done, pass, err_vec, timeout_vec}), 64'(0));
        step();
        rst = 1'b0;

        // Reset in the middle of a launch pulse.
        set_cfg(0, 0, 0, 0, 4'b0000);
        begin_run(1'b1, 4'b0100, n);
        while (cyc < n + 1 + SD) begin
            step();
            start = 1'b0;
        end
        check("pre_reset launch", 64'(init_axi_txn), 64'(4'b0100));
        #1 rst = 1'b1;
        #1 check("async_reset_launch init_busy", 64'({init_axi_txn, busy}), 64'(0));
        step();
        rst = 1'b0;
        set_cfg(20, 30, 0, 0, 4'b0000);
        run("after_reset", 1'b0, 4'b0011, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NM; i++)
                dly_cfg[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO + 20));
            err_cfg = 4'($urandom) & 4'($urandom);
            run("random", 1'($urandom), 4'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
